// File: rtl/fp_align_pkg.sv
// fp_align_pkg
//   Shared types and widths for the floating-point operand-alignment pipeline.
//   The *_DEF widths are the default operand geometry. The struct types below
//   are sized from them, so any parameter override of fp_align_pipe must keep
//   the same widths.
//   Contents:
//     ALN_W       - width of the aligned mantissa field (mantissa + guard bits)
//     operand_t   - one unpacked operand (sign, biased exponent, mantissa)
//     s1_bundle_t - register contents of the compare/select stage
package fp_align_pkg;

  localparam int EXP_W_DEF  = 4;
  localparam int MANT_W_DEF = 4;
  localparam int GRD_W_DEF  = 2;
  localparam int ALN_W      = MANT_W_DEF + GRD_W_DEF;

  typedef struct packed {
    logic                  sign;
    logic [EXP_W_DEF-1:0]  exp;
    logic [MANT_W_DEF-1:0] mant;
  } operand_t;

  // The small operand's exponent is not carried forward. Only the distance
  // to the big exponent matters after selection.
  typedef struct packed {
    operand_t              big;
    logic                  small_sign;
    logic [MANT_W_DEF-1:0] small_mant;
    logic [EXP_W_DEF-1:0]  diff;
    logic                  swap;
  } s1_bundle_t;

endpackage

// File: rtl/fp_align_shifter.sv
// fp_align_shifter
//   Combinational right shifter for the small mantissa. It optionally
//   generates a sticky bit.
//   Build option: FP_ALIGN_STICKY_EN adds the sticky output. Without it the
//   port and its logic do not exist.
//   Ports:
//     din    [W-1:0]    mantissa with guard bits already appended
//     shamt  [SH_W-1:0] right-shift distance (exponent difference)
//     dout   [W-1:0]    din >> shamt; all zeros once shamt >= W
//     sticky            OR of every din bit pushed below bit 0 (macro only)
module fp_align_shifter
  import fp_align_pkg::*;
#(
  parameter int W    = ALN_W,
  parameter int SH_W = EXP_W_DEF
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] shamt,
  output logic [W-1:0]    dout
`ifdef FP_ALIGN_STICKY_EN
  ,
  output logic            sticky
`endif
);

  // Shifts larger than the field width must yield zero explicitly. The
  // shift amount may be wider than log2(W).
  assign dout = (32'(shamt) >= W) ? '0 : (din >> shamt);

`ifdef FP_ALIGN_STICKY_EN
  // Bit gi falls off the bottom exactly when gi < shamt. This also covers
  // the over-range case, where every bit is lost.
  logic [W-1:0] lost;

  for (genvar gi = 0; gi < W; gi++) begin : gen_lost
    assign lost[gi] = din[gi] & (32'(shamt) > gi);
  end

  assign sticky = |lost;
`endif

endmodule

// File: rtl/fp_align_pipe.sv
// fp_align_pipe
//   Two-stage, valid/ready pipelined alignment unit for FP add/sub.
//   Stage 1 selects the larger-magnitude operand and registers the exponent
//   distance. Stage 2 right-aligns the smaller mantissa (guard bits appended)
//   and registers the result.
//   Build option: FP_ALIGN_STICKY_EN enables sticky generation. Otherwise
//   sticky is tied to 0.
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     in_valid / in_ready      input handshake for one operand pair
//     a_*/b_*                  unpacked operands (sign, exp, mant)
//     out_valid / out_ready    output handshake
//     big_sign, small_sign     signs of the selected big/small operands
//     big_exp                  common (larger) exponent
//     big_mant, small_mant     aligned mantissas, MANT_W+GRD_W bits
//     sticky                   OR of small-mantissa bits shifted out
//     swap                     1 when B was chosen as the big operand
module fp_align_pipe
  import fp_align_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF,
  parameter int GRD_W  = GRD_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    a_sign,
  input  logic [EXP_W-1:0]        a_exp,
  input  logic [MANT_W-1:0]       a_mant,
  input  logic                    b_sign,
  input  logic [EXP_W-1:0]        b_exp,
  input  logic [MANT_W-1:0]       b_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    big_sign,
  output logic                    small_sign,
  output logic [EXP_W-1:0]        big_exp,
  output logic [MANT_W+GRD_W-1:0] big_mant,
  output logic [MANT_W+GRD_W-1:0] small_mant,
  output logic                    sticky,
  output logic                    swap
);

  localparam int AW = MANT_W + GRD_W;

  logic       s1_valid_reg;
  logic       s2_valid_reg;
  s1_bundle_t s1_reg;
  s1_bundle_t s1_next;
  logic       s1_load;
  logic       s2_load;
  logic       b_big;

  // A stage may load when the stage after it is empty or is being drained
  // this cycle. This gives full throughput with no bubble.
  assign s2_load   = !s2_valid_reg || out_ready;
  assign s1_load   = !s1_valid_reg || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid_reg;

  // ---------------- stage 1: compare / select ----------------
  // B wins only when it is strictly larger. A full tie therefore keeps A as
  // big (swap=0). The subtraction is always larger minus smaller, so it
  // cannot wrap.
  always_comb begin
    s1_next = '0;
    b_big   = (b_exp > a_exp) || ((b_exp == a_exp) && (b_mant > a_mant));
    s1_next.swap = b_big;
    if (b_big) begin
      s1_next.big.sign   = b_sign;
      s1_next.big.exp    = b_exp;
      s1_next.big.mant   = b_mant;
      s1_next.small_sign = a_sign;
      s1_next.small_mant = a_mant;
      s1_next.diff       = b_exp - a_exp;
    end else begin
      s1_next.big.sign   = a_sign;
      s1_next.big.exp    = a_exp;
      s1_next.big.mant   = a_mant;
      s1_next.small_sign = b_sign;
      s1_next.small_mant = b_mant;
      s1_next.diff       = a_exp - b_exp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_reg       <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_reg <= s1_next;
      end
    end
  end

  // ---------------- stage 2: align ----------------
  logic [AW-1:0] sh_mant;

`ifdef FP_ALIGN_STICKY_EN
  logic sh_sticky;

  fp_align_shifter #(
    .W    (AW),
    .SH_W (EXP_W)
  ) u_shifter (
    .din    ({s1_reg.small_mant, {GRD_W{1'b0}}}),
    .shamt  (s1_reg.diff),
    .dout   (sh_mant),
    .sticky (sh_sticky)
  );
`else
  fp_align_shifter #(
    .W    (AW),
    .SH_W (EXP_W)
  ) u_shifter (
    .din   ({s1_reg.small_mant, {GRD_W{1'b0}}}),
    .shamt (s1_reg.diff),
    .dout  (sh_mant)
  );

  assign sticky = 1'b0;
`endif

  // The output registers change only when a new pair moves in. This keeps
  // them stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      big_sign     <= 1'b0;
      small_sign   <= 1'b0;
      big_exp      <= '0;
      big_mant     <= '0;
      small_mant   <= '0;
      swap         <= 1'b0;
`ifdef FP_ALIGN_STICKY_EN
      sticky       <= 1'b0;
`endif
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        big_sign   <= s1_reg.big.sign;
        small_sign <= s1_reg.small_sign;
        big_exp    <= s1_reg.big.exp;
        big_mant   <= {s1_reg.big.mant, {GRD_W{1'b0}}};
        small_mant <= sh_mant;
        swap       <= s1_reg.swap;
`ifdef FP_ALIGN_STICKY_EN
        sticky     <= sh_sticky;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp_align_pipe.sv
// tb_fp_align_pipe
//   Self-checking bench for fp_align_pipe at EXP_W=4, MANT_W=4, GRD_W=2.
//   It uses a table of hand-derived vectors, streaming/back-pressure and
//   mid-flight reset sequences, and randomized traffic. The randomized
//   traffic is checked against an arithmetic reference model and an
//   in-order scoreboard. Sticky expectations follow FP_ALIGN_STICKY_EN.
`timescale 1ns/1ps
module tb_fp_align_pipe;

`ifdef FP_ALIGN_STICKY_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  typedef struct {
    logic       s;
    logic [3:0] e;
    logic [3:0] m;
  } op_t;

  typedef struct {
    logic       swap;
    logic       bsign;
    logic       ssign;
    logic [3:0] bexp;
    logic [5:0] bmant;
    logic [5:0] smant;
    logic       stk;
    int         cyc;
  } res_t;

  typedef struct {
    op_t  a;
    op_t  b;
    res_t r;  // sticky column is the value with sticky enabled
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic       a_sign, b_sign;
  logic [3:0] a_exp, a_mant, b_exp, b_mant;
  logic       out_valid, out_ready;
  logic       big_sign, small_sign, sticky, swap;
  logic [3:0] big_exp;
  logic [5:0] big_mant, small_mant;

  always #5 clk = ~clk;

  fp_align_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_sign     (a_sign),
    .a_exp      (a_exp),
    .a_mant     (a_mant),
    .b_sign     (b_sign),
    .b_exp      (b_exp),
    .b_mant     (b_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .big_sign   (big_sign),
    .small_sign (small_sign),
    .big_exp    (big_exp),
    .big_mant   (big_mant),
    .small_mant (small_mant),
    .sticky     (sticky),
    .swap       (swap)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  res_t sb[$];
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  // Reference model: magnitude is compared as exp*16+mant, and the
  // alignment is plain integer arithmetic on the mantissa scaled by 4
  // (two guard bits).
  function automatic res_t model(input op_t a, input op_t b);
    res_t r;
    op_t  big, sml;
    int   d, sx;
    bit   bbig;
    bbig = (int'(b.e) * 16 + int'(b.m)) > (int'(a.e) * 16 + int'(a.m));
    big  = bbig ? b : a;
    sml  = bbig ? a : b;
    d    = int'(big.e) - int'(sml.e);
    sx   = int'(sml.m) * 4;
    r.swap  = bbig;
    r.bsign = big.s;
    r.ssign = sml.s;
    r.bexp  = big.e;
    r.bmant = 6'(int'(big.m) * 4);
    r.smant = 6'(sx >> d);
    r.stk   = STK_EN && ((sx % (1 << d)) != 0);
    r.cyc   = 0;
    return r;
  endfunction

  function automatic res_t tv_exp(input int i);
    res_t r;
    r     = tv[i].r;
    r.stk = tv[i].r.stk & STK_EN;
    return r;
  endfunction

  // One clock cycle: drive at the falling edge, check just after, update
  // the scoreboard according to the handshakes expected at the next
  // rising edge.
  task automatic step(input logic iv, input op_t a, input op_t b, input logic ordy, input res_t ev);
    logic exp_ir, exp_ov;
    @(negedge clk);
    in_valid  = iv;
    a_sign    = a.s; a_exp = a.e; a_mant = a.m;
    b_sign    = b.s; b_exp = b.e; b_mant = b.m;
    out_ready = ordy;
    #1;
    exp_ir = !(sb.size() == 2 && !ordy);
    exp_ov = (sb.size() > 0) && (sb[0].cyc <= cyc - 2);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov && out_valid) begin
      chk("swap", 32'(swap), 32'(sb[0].swap));
      chk("big_sign", 32'(big_sign), 32'(sb[0].bsign));
      chk("small_sign", 32'(small_sign), 32'(sb[0].ssign));
      chk("big_exp", 32'(big_exp), 32'(sb[0].bexp));
      chk("big_mant", 32'(big_mant), 32'(sb[0].bmant));
      chk("small_mant", 32'(small_mant), 32'(sb[0].smant));
      chk("sticky", 32'(sticky), 32'(sb[0].stk));
      if (ordy)
        $display("txn cyc=%0d swap=%0b bexp=%0d bmant=%b smant=%b sticky=%0b",
                 cyc, swap, big_exp, big_mant, small_mant, sticky);
    end
    if (exp_ov && ordy) void'(sb.pop_front());
    if (iv && exp_ir) begin
      ev.cyc = cyc;
      sb.push_back(ev);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, tv[0].a, tv[0].b, ordy, tv_exp(0));
  endtask

  task automatic drain();
    for (int n = 0; n < 10 && sb.size() > 0; n++) idle(1'b1);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_data"}, {big_sign, small_sign, big_exp, big_mant, small_mant, sticky, swap}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    op_t oa, ob;
    // a(s,e,m), b(s,e,m), expected {swap, bsign, ssign, bexp, bmant, smant, sticky}
    tv[0] = '{'{0, 5, 4'b1010}, '{1, 3, 4'b1100}, '{0, 0, 1, 5, 6'b101000, 6'b001100, 0, 0}};
    tv[1] = '{'{1, 1, 4'b1001}, '{0, 7, 4'b1111}, '{1, 0, 1, 7, 6'b111100, 6'b000000, 1, 0}};
    tv[2] = '{'{0, 4, 4'b0110}, '{1, 4, 4'b1001}, '{1, 1, 0, 4, 6'b100100, 6'b011000, 0, 0}};
    tv[3] = '{'{1, 4, 4'b0110}, '{0, 4, 4'b0110}, '{0, 1, 0, 4, 6'b011000, 6'b011000, 0, 0}};
    tv[4] = '{'{0, 9, 4'b1111}, '{0, 6, 4'b1011}, '{0, 0, 0, 9, 6'b111100, 6'b000101, 1, 0}};
    tv[5] = '{'{0, 2, 4'b0001}, '{1, 2, 4'b0000}, '{0, 0, 1, 2, 6'b000100, 6'b000000, 0, 0}};
    tv[6] = '{'{0, 0, 4'b0011}, '{1, 15, 4'b0001}, '{1, 1, 0, 15, 6'b000100, 6'b000000, 1, 0}};
    tv[7] = '{'{1, 10, 4'b1000}, '{0, 5, 4'b1000}, '{0, 1, 0, 10, 6'b100000, 6'b000001, 0, 0}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_sign = 0; a_exp = 0; a_mant = 0; b_sign = 0; b_exp = 0; b_mant = 0;
    repeat (2) @(posedge clk);
    #1 chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // isolated table vectors
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tv[i].a, tv[i].b, 1'b1, tv_exp(i));
      repeat (3) idle(1'b1);
    end
    drain();

    // 4 back-to-back pairs, then 3 cycles of back-pressure with input offered
    for (int i = 0; i < 4; i++) step(1'b1, tv[i].a, tv[i].b, 1'b1, tv_exp(i));
    for (int i = 4; i < 7; i++) step(1'b1, tv[i].a, tv[i].b, 1'b0, tv_exp(i));
    drain();

    // fill both stages, then reset asynchronously mid-cycle
    step(1'b1, tv[1].a, tv[1].b, 1'b0, tv_exp(1));
    step(1'b1, tv[2].a, tv[2].b, 1'b0, tv_exp(2));
    idle(1'b0);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, tv[4].a, tv[4].b, 1'b1, tv_exp(4));
    repeat (3) idle(1'b1);
    drain();

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      oa = '{1'($urandom), 4'($urandom), 4'($urandom)};
      ob = '{1'($urandom), 4'($urandom), 4'($urandom)};
      if ($urandom_range(0, 7) == 0) ob.e = oa.e;
      step($urandom_range(0, 3) != 0, oa, ob, $urandom_range(0, 2) != 0, model(oa, ob));
    end
    drain();

    summary();
    $finish;
  end

endmodule
